data_memory_sized: RTL
======================

// Module: data_memory_sized
// PURPOSE
//   Byte-addressed, word-organised data memory for the RV32IM MEM stage.
//   Supports all RV32 load/store sizes (LB/LH/LW/LBU/LHU/SB/SH/SW) with per-byte
//   lane write enables and load sign/zero extension.
//   Has a parametrised access latency with a busywait stall handshake to the
//   pipeline, plus misalignment detection.
// PARAMETERS
//   ADDR_W   10  byte-address width; depth = 2**(ADDR_W-2) 32-bit words
//   LATENCY  4   clock edges from request accept to completion; legal range 1..255
// PORTS
//   clock      in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   read       in   1       load request
//   write      in   1       store request
//   func3      in   3       RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address    in   ADDR_W  byte address
//   writedata  in   32      store data; low bytes used for SB/SH
//   readdata   out  32      extended load result
//   busywait   out  1       stall pipeline while high
//   misaligned out  1       last completed access was misaligned and was suppressed
// BEHAVIOUR
//   Reset (async, any time, including mid-access):
//   - FSM goes to IDLE; readdata=0, busywait=0, misaligned=0; the pending access is dropped.
//   - All words are zeroed (behavioural model).
//   Request validity: valid = read XOR write. read&write both high is ignored: no access, busywait stays 0.
//   FSM states:
//   - IDLE: busywait = valid (combinational). On a clock edge with valid, capture address, func3,
//     writedata and the op; counter <= LATENCY-1. Go to DONE if LATENCY==1, else BUSY.
//   - BUSY: busywait=1. Counter decrements each edge. When counter==1, go to DONE.
//     Inputs are ignored; only the captured values are used.
//   - DONE: busywait=1. On the next edge, perform the access, update readdata/misaligned,
//     and go to IDLE (busywait falls after that edge).
//   - Net timing: request presented in cycle 0; access at edge LATENCY; the pipeline advances
//     in cycle LATENCY+1.
//   Lanes: little-endian. Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
//   Store: SB writes 1 byte at lane; SH writes lanes {a1,0},{a1,1}; SW writes all 4 lanes.
//     Unwritten lanes are unchanged.
//   Load: B/BU take the byte at lane and sign/zero-extend it. H/HU take the halfword at
//     lane a1 and sign/zero-extend it. W returns the full word.
//   Misaligned: H/HU/SH with a0=1, or W/SW with a[1:0]!=0.
//   - Memory is not written; readdata is unchanged on loads; misaligned=1.
//   - Timing is the same as a normal access.
//   Illegal func3 (011/110/111): completes with no write; readdata=0 on loads; misaligned=0.
//   misaligned and readdata hold their values until the next access completes.
//   A store never changes readdata.
//   Back-to-back: a request held high after completion is accepted again in the IDLE cycle
//     (the pipeline is expected to have advanced). No request queue; one access in flight.
// TESTING
//   1. Reset, then LW addr 0x000: readdata=0; busywait high for exactly LATENCY+1 cycles
//      (cycles 0..LATENCY).
//   2. SW 0x8765_43A1 @0x010, then LB/LBU/LH/LHU @0x010 and LB @0x013:
//      0xFFFF_FFA1, 0x0000_00A1, 0x0000_43A1, 0x0000_43A1, 0xFFFF_FF87.
//   3. SB 0x55 @0x021 over word 0xAABB_CCDD @0x020, then LW @0x020:
//      0xAABB_55DD. SH 0xBEEF @0x022, then LW: 0xBEEF_55DD.
//   4. SW @0x006 and LH @0x003: misaligned=1, word 0x004 unchanged, readdata unchanged.
//      A following aligned LW clears misaligned to 0.
//   5. Assert reset at LATENCY/2 of an SW 0xFFFF_FFFF @0x040: busywait drops immediately;
//      a later LW @0x040 returns 0.
//   6. Repeat tests 1-2 with LATENCY=1 and ADDR_W=12 (highest word 0xFFC):
//      one-cycle stall; top word read/write correct.

Source files
------------

// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_sized
//  Description : Byte-addressed, word-organised data memory for the RV32IM
//                MEM stage. Handles LB/LH/LW/LBU/LHU/SB/SH/SW with per-lane
//                write enables, load sign/zero extension, a parametrised
//                access latency with a busywait stall, and misalignment
//                detection (misaligned accesses are suppressed).
//  Ports       : clock      - rising-edge clock
//                reset      - asynchronous active-high reset
//                read       - load request
//                write      - store request
//                func3      - RV32 funct3 (size / signedness)
//                address    - byte address
//                writedata  - store data (low bytes used for SB/SH)
//                readdata   - extended load result (held until next load)
//                busywait   - stall request to the pipeline
//                misaligned - last completed access was misaligned
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_sized #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              busywait,
    output logic              misaligned
);

    localparam int         c_DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [7:0] c_LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_func3;
    logic [31:0]         r_wdata;
    logic                r_is_write;
    logic [31:0]         r_readdata;
    logic                r_misaligned;
    logic [31:0]         r_mem [c_DEPTH];

    logic                w_valid;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_illegal;
    logic                w_misaligned;
    logic [31:0]         w_load_val;
    logic [3:0]          w_be;
    logic [31:0]         w_wlanes;

    // read and write together is not a request at all
    assign w_valid = read ^ write;

    // The access itself only ever looks at the captured request
    assign w_word = r_mem[r_addr[ADDR_W-1:2]];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_illegal = (r_func3 == 3'b011) || (r_func3 == 3'b110) || (r_func3 == 3'b111);

    // Only legal encodings can be misaligned; illegal ones have no size
    assign w_misaligned = !w_illegal &&
                          (((r_func3[1:0] == 2'b01) && r_addr[0]) ||
                           ((r_func3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)));

    always_comb begin
        w_load_val = 32'd0;
        case (r_func3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_val = w_word;
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = 32'd0;
        endcase
    end

    // Store data replicated across lanes so the lane enables pick the right copy
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_func3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= 8'd0;
            r_addr       <= '0;
            r_func3      <= 3'd0;
            r_wdata      <= 32'd0;
            r_is_write   <= 1'b0;
            r_readdata   <= 32'd0;
            r_misaligned <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_addr     <= address;
                        r_func3    <= func3;
                        r_wdata    <= writedata;
                        r_is_write <= write;
                        r_count    <= c_LAT_M1;
                        r_state    <= (LATENCY == 1) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_count <= r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_misaligned) begin
                        r_misaligned <= 1'b1;
                    end else if (w_illegal) begin
                        r_misaligned <= 1'b0;
                        if (!r_is_write) begin
                            r_readdata <= 32'd0;
                        end
                    end else begin
                        r_misaligned <= 1'b0;
                        if (r_is_write) begin
                            for (int i = 0; i < 4; i++) begin
                                if (w_be[i]) begin
                                    r_mem[r_addr[ADDR_W-1:2]][8*i +: 8] <= w_wlanes[8*i +: 8];
                                end
                            end
                        end else begin
                            r_readdata <= w_load_val;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // In IDLE the stall is raised combinationally so the request cycle itself stalls
    assign busywait   = (r_state != S_IDLE) || w_valid;
    assign readdata   = r_readdata;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire
